parking_gate_ctrl: RTL and testbench

PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

---
 rtl/parking_gate_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: password-checked entry, tailgate stop, lockout
// after repeated wrong passwords, saturating occupancy count and
// registered lamp / seven-segment outputs.
module parking_gate_ctrl #(
  parameter int                CAPACITY  = 8,
  parameter int                PASS_W    = 2,
  parameter logic [PASS_W-1:0] KEY_1     = PASS_W'(1),
  parameter logic [PASS_W-1:0] KEY_2     = PASS_W'(2),
  parameter int                WAIT_CYC  = 4,
  parameter int                MAX_TRIES = 3,
  parameter int                LOCK_CYC  = 16,
  parameter int                BLINK_DIV = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             sensor_ent,
  input  logic                             sensor_exit,
  input  logic                             car_out,
  input  logic [PASS_W-1:0]                pass_1,
  input  logic [PASS_W-1:0]                pass_2,
  input  logic                             pass_valid,
  output logic                             green_led,
  output logic                             red_led,
  output logic [6:0]                       hex_1,
  output logic [6:0]                       hex_2,
  output logic [$clog2(CAPACITY+1)-1:0]    occupancy,
  output logic                             full
);

  localparam int OCC_W   = $clog2(CAPACITY + 1);
  localparam int WAIT_W  = (WAIT_CYC  > 1) ? $clog2(WAIT_CYC)  : 1;
  localparam int LOCK_W  = (LOCK_CYC  > 1) ? $clog2(LOCK_CYC)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);

  localparam logic [OCC_W-1:0]   OCC_MAX    = OCC_W'(CAPACITY);
  localparam logic [OCC_W-1:0]   OCC_ONE    = OCC_W'(1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(WAIT_CYC - 1);
  localparam logic [WAIT_W-1:0]  WAIT_ONE   = WAIT_W'(1);
  localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCK_CYC - 1);
  localparam logic [LOCK_W-1:0]  LOCK_ONE   = LOCK_W'(1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);
  localparam logic [TRY_W-1:0]   TRY_ONE    = TRY_W'(1);
  localparam logic [TRY_W-1:0]   TRY_MAX    = TRY_W'(MAX_TRIES);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_WRONG  = 3'd2;
  localparam logic [2:0] S_RIGHT  = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_LOCKED = 3'd5;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_G     = 7'b0000010;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_C     = 7'b1000110;

  logic [2:0]         r_state;
  logic [2:0]         r_out_state;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [LOCK_W-1:0]  r_lock_cnt;
  logic [TRY_W-1:0]   r_tries;
  logic [OCC_W-1:0]   r_occ;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink;
  logic               r_green;
  logic               r_red;
  logic [6:0]         r_hex_1;
  logic [6:0]         r_hex_2;

  logic [2:0]         w_state_next;
  logic [TRY_W-1:0]   w_tries_next;
  logic [TRY_W-1:0]   w_tries_inc;
  logic               w_match;
  logic               w_full;
  logic               w_admit;
  logic               w_blink_now;
  logic               w_green;
  logic               w_red;
  logic [6:0]         w_hex_1;
  logic [6:0]         w_hex_2;

  assign w_match     = (pass_1 == KEY_1) && (pass_2 == KEY_2);
  assign w_full      = (r_occ == OCC_MAX);
  assign w_tries_inc = r_tries + TRY_ONE;
  // A car is admitted when it clears the exit sensor without a tailgater behind it.
  assign w_admit     = (r_state == S_RIGHT) && sensor_exit && !sensor_ent;

  // Next-state and tries decode.
  always_comb begin
    w_state_next = r_state;
    w_tries_next = r_tries;
    case (r_state)
      S_IDLE: begin
        if (sensor_ent && !w_full) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (r_wait_cnt == WAIT_LAST) begin
          if (w_match) begin
            w_state_next = S_RIGHT;
          end else begin
            w_tries_next = TRY_ONE;
            w_state_next = (TRY_ONE == TRY_MAX) ? S_LOCKED : S_WRONG;
          end
        end
      end
      S_WRONG, S_STOP: begin
        if (pass_valid) begin
          if (w_match) begin
            w_state_next = S_RIGHT;
          end else begin
            w_tries_next = w_tries_inc;
            if (w_tries_inc == TRY_MAX) w_state_next = S_LOCKED;
          end
        end
      end
      S_RIGHT: begin
        if (sensor_ent && sensor_exit) w_state_next = S_STOP;
        else if (sensor_exit)          w_state_next = S_IDLE;
      end
      S_LOCKED: begin
        if (r_lock_cnt == LOCK_LAST) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (w_state_next == S_IDLE || w_state_next == S_RIGHT) w_tries_next = '0;
  end

  // State, tries and the per-state dwell counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_tries    <= '0;
      r_wait_cnt <= '0;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_tries    <= w_tries_next;
      r_wait_cnt <= (r_state == S_WAIT && w_state_next == S_WAIT) ? r_wait_cnt + WAIT_ONE : '0;
      r_lock_cnt <= (r_state == S_LOCKED && w_state_next == S_LOCKED) ? r_lock_cnt + LOCK_ONE : '0;
    end
  end

  // Occupancy: an admission and a departure in the same cycle cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occ <= '0;
    end else if (w_admit && !car_out) begin
      if (r_occ < OCC_MAX) r_occ <= r_occ + OCC_ONE;
    end else if (car_out && !w_admit) begin
      if (r_occ != '0) r_occ <= r_occ - OCC_ONE;
    end
  end

  // Blink phase restarts high whenever the displayed state changes.
  assign w_blink_now = (r_state != r_out_state) ? 1'b1 :
                       (r_blink_cnt == BLINK_LAST) ? ~r_blink : r_blink;

  // Per-state lamp and display decode.
  always_comb begin
    w_green = 1'b0;
    w_red   = 1'b0;
    w_hex_1 = SEG_BLANK;
    w_hex_2 = SEG_BLANK;
    case (r_state)
      S_IDLE: begin
        if (w_full && sensor_ent) begin
          w_hex_1 = SEG_F;
          w_hex_2 = SEG_U;
        end
      end
      S_WAIT:   begin w_red = 1'b1;        w_hex_1 = SEG_E; w_hex_2 = SEG_N; end
      S_WRONG:  begin w_red = w_blink_now; w_hex_1 = SEG_E; w_hex_2 = SEG_E; end
      S_RIGHT:  begin w_green = w_blink_now; w_hex_1 = SEG_G; w_hex_2 = SEG_O; end
      S_STOP:   begin w_red = w_blink_now; w_hex_1 = SEG_S; w_hex_2 = SEG_P; end
      S_LOCKED: begin w_red = 1'b1;        w_hex_1 = SEG_L; w_hex_2 = SEG_C; end
      default:  ;
    endcase
  end

  // Output registers trail the state register by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_state <= S_IDLE;
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
      r_green     <= 1'b0;
      r_red       <= 1'b0;
      r_hex_1     <= SEG_BLANK;
      r_hex_2     <= SEG_BLANK;
    end else begin
      r_out_state <= r_state;
      r_blink     <= w_blink_now;
      if (r_state != r_out_state || r_blink_cnt == BLINK_LAST) r_blink_cnt <= '0;
      else                                                      r_blink_cnt <= r_blink_cnt + BLINK_ONE;
      r_green     <= w_green;
      r_red       <= w_red;
      r_hex_1     <= w_hex_1;
      r_hex_2     <= w_hex_2;
    end
  end

  assign green_led = r_green;
  assign red_led   = r_red;
  assign hex_1     = r_hex_1;
  assign hex_2     = r_hex_2;
  assign occupancy = r_occ;
  assign full      = w_full;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl (CAPACITY=2, other parameters default):
// a cycle-by-cycle vector table plus hand-written lockout and reset sequences.
module tb_parking_gate_ctrl;

  localparam logic [6:0] BLK = 7'h7F;
  localparam logic [6:0] SE  = 7'b0000110;
  localparam logic [6:0] SN  = 7'b0101011;
  localparam logic [6:0] SG  = 7'b0000010;
  localparam logic [6:0] SO  = 7'b1000000;
  localparam logic [6:0] SS  = 7'b0010010;
  localparam logic [6:0] SP  = 7'b0001100;
  localparam logic [6:0] SF  = 7'b0001110;
  localparam logic [6:0] SU  = 7'b1000001;
  localparam logic [6:0] SL  = 7'b1000111;
  localparam logic [6:0] SC  = 7'b1000110;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor_ent, sensor_exit, car_out, pass_valid;
  logic [1:0] pass_1, pass_2;
  logic       green_led, red_led, full;
  logic [6:0] hex_1, hex_2;
  logic [1:0] occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  parking_gate_ctrl #(.CAPACITY(2)) dut (
    .clk(clk), .reset(reset),
    .sensor_ent(sensor_ent), .sensor_exit(sensor_exit), .car_out(car_out),
    .pass_1(pass_1), .pass_2(pass_2), .pass_valid(pass_valid),
    .green_led(green_led), .red_led(red_led),
    .hex_1(hex_1), .hex_2(hex_2),
    .occupancy(occupancy), .full(full)
  );

  always #5 clk = ~clk;

  // observed outputs packed as {green, red, hex_1, hex_2, occupancy, full}
  logic [18:0] obs;
  assign obs = {green_led, red_led, hex_1, hex_2, occupancy, full};

  typedef struct packed {
    logic        ent, ex, cout, pv;
    logic [1:0]  p1, p2;
    logic [18:0] exp;
  } vec_t;

  vec_t tbl [30];

  function automatic logic [18:0] o(input logic g, input logic r, input logic [6:0] h1,
                                    input logic [6:0] h2, input logic [1:0] oc, input logic f);
    return {g, r, h1, h2, oc, f};
  endfunction

  function automatic vec_t v(input logic ent, input logic ex, input logic cout, input logic pv,
                             input logic [1:0] p1, input logic [1:0] p2, input logic [18:0] e);
    vec_t t;
    t.ent = ent; t.ex = ex; t.cout = cout; t.pv = pv;
    t.p1 = p1; t.p2 = p2; t.exp = e;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic drive(input logic ent, input logic ex, input logic cout, input logic pv,
                       input logic [1:0] p1, input logic [1:0] p2);
    sensor_ent = ent; sensor_exit = ex; car_out = cout; pass_valid = pv;
    pass_1 = p1; pass_2 = p2;
  endtask

  // one clock: apply inputs, take the rising edge, settle just after it
  task automatic step(input logic ent, input logic ex, input logic cout, input logic pv,
                      input logic [1:0] p1, input logic [1:0] p2);
    drive(ent, ex, cout, pv, p1, p2);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- vector table: main flow, tailgate, full, same-cycle in/out ----
    tbl[0]  = v(1,0,0,0, 2'd1,2'd2, o(0,0,BLK,BLK,2'd0,0));
    tbl[1]  = v(1,0,0,0, 2'd1,2'd2, o(0,1,SE ,SN ,2'd0,0));
    tbl[2]  = v(1,0,0,0, 2'd1,2'd2, o(0,1,SE ,SN ,2'd0,0));
    tbl[3]  = v(1,0,0,0, 2'd1,2'd2, o(0,1,SE ,SN ,2'd0,0));
    tbl[4]  = v(1,0,0,0, 2'd1,2'd2, o(0,1,SE ,SN ,2'd0,0));
    tbl[5]  = v(0,0,0,0, 2'd1,2'd2, o(1,0,SG ,SO ,2'd0,0));
    tbl[6]  = v(0,0,0,0, 2'd1,2'd2, o(0,0,SG ,SO ,2'd0,0));
    tbl[7]  = v(0,1,0,0, 2'd1,2'd2, o(1,0,SG ,SO ,2'd1,0));
    tbl[8]  = v(0,0,0,0, 2'd0,2'd0, o(0,0,BLK,BLK,2'd1,0));
    tbl[9]  = v(1,0,0,0, 2'd1,2'd2, o(0,0,BLK,BLK,2'd1,0));
    tbl[10] = v(1,0,0,0, 2'd1,2'd2, o(0,1,SE ,SN ,2'd1,0));
    tbl[11] = v(1,0,0,0, 2'd1,2'd2, o(0,1,SE ,SN ,2'd1,0));
    tbl[12] = v(1,0,0,0, 2'd1,2'd2, o(0,1,SE ,SN ,2'd1,0));
    tbl[13] = v(1,0,0,0, 2'd1,2'd2, o(0,1,SE ,SN ,2'd1,0));
    tbl[14] = v(1,1,0,0, 2'd1,2'd2, o(1,0,SG ,SO ,2'd1,0));
    tbl[15] = v(0,0,0,0, 2'd0,2'd0, o(0,1,SS ,SP ,2'd1,0));
    tbl[16] = v(0,0,0,1, 2'd0,2'd0, o(0,0,SS ,SP ,2'd1,0));
    tbl[17] = v(0,0,0,1, 2'd1,2'd2, o(0,1,SS ,SP ,2'd1,0));
    tbl[18] = v(0,1,0,0, 2'd0,2'd0, o(1,0,SG ,SO ,2'd2,1));
    tbl[19] = v(1,0,0,0, 2'd1,2'd2, o(0,0,SF ,SU ,2'd2,1));
    tbl[20] = v(1,0,1,0, 2'd1,2'd2, o(0,0,SF ,SU ,2'd1,0));
    tbl[21] = v(0,0,0,0, 2'd0,2'd0, o(0,0,BLK,BLK,2'd1,0));
    tbl[22] = v(1,0,0,0, 2'd1,2'd2, o(0,0,BLK,BLK,2'd1,0));
    tbl[23] = v(1,0,0,0, 2'd1,2'd2, o(0,1,SE ,SN ,2'd1,0));
    tbl[24] = v(1,0,0,0, 2'd1,2'd2, o(0,1,SE ,SN ,2'd1,0));
    tbl[25] = v(1,0,0,0, 2'd1,2'd2, o(0,1,SE ,SN ,2'd1,0));
    tbl[26] = v(1,0,0,0, 2'd1,2'd2, o(0,1,SE ,SN ,2'd1,0));
    tbl[27] = v(0,1,1,0, 2'd0,2'd0, o(1,0,SG ,SO ,2'd1,0));
    tbl[28] = v(0,0,1,0, 2'd0,2'd0, o(0,0,BLK,BLK,2'd0,0));
    tbl[29] = v(0,0,1,0, 2'd0,2'd0, o(0,0,BLK,BLK,2'd0,0));

    // ---- reset ----
    reset = 1'b0;
    drive(0,0,0,0, 2'd0,2'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(obs), 32'(o(0,0,BLK,BLK,2'd0,0)));
    reset = 1'b1;

    for (int i = 0; i < 30; i++) begin
      step(tbl[i].ent, tbl[i].ex, tbl[i].cout, tbl[i].pv, tbl[i].p1, tbl[i].p2);
      chk($sformatf("vec%0d", i), 32'(obs), 32'(tbl[i].exp));
    end

    // ---- wrong password, retries and lockout ----
    step(1,0,0,0, 2'd0,2'd0);
    repeat (4) step(0,0,0,0, 2'd0,2'd0);
    chk("tries_after_wait", 32'(dut.r_tries), 32'd1);
    step(0,0,0,0, 2'd0,2'd0);
    chk("wrong_first", 32'(obs), 32'(o(0,1,SE,SE,2'd0,0)));
    step(0,0,0,0, 2'd0,2'd0);
    chk("wrong_blink", 32'(obs), 32'(o(0,0,SE,SE,2'd0,0)));
    step(0,0,0,1, 2'd0,2'd0);
    chk("tries_second", 32'(dut.r_tries), 32'd2);
    step(0,0,0,0, 2'd0,2'd0);
    step(0,0,0,1, 2'd0,2'd0);
    chk("tries_third", 32'(dut.r_tries), 32'd3);
    step(1,0,0,1, 2'd1,2'd2);
    chk("locked_first", 32'(obs), 32'(o(0,1,SL,SC,2'd0,0)));
    for (int i = 0; i < 15; i++) step(1,0,0,1, 2'd1,2'd2);
    chk("locked_last", 32'(obs), 32'(o(0,1,SL,SC,2'd0,0)));
    step(0,0,0,0, 2'd0,2'd0);
    chk("unlock_idle", 32'(obs), 32'(o(0,0,BLK,BLK,2'd0,0)));
    chk("unlock_tries", 32'(dut.r_tries), 32'd0);

    // ---- asynchronous reset in WRONG_PASS with tries=2 ----
    step(1,0,0,0, 2'd1,2'd2);
    repeat (4) step(0,0,0,0, 2'd1,2'd2);
    step(0,1,0,0, 2'd0,2'd0);
    step(0,0,0,0, 2'd0,2'd0);
    chk("admit_occ", 32'(occupancy), 32'd1);
    step(1,0,0,0, 2'd0,2'd0);
    repeat (4) step(0,0,0,0, 2'd0,2'd0);
    step(0,0,0,1, 2'd0,2'd0);
    chk("pre_reset_tries", 32'(dut.r_tries), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", 32'(obs), 32'(o(0,0,BLK,BLK,2'd0,0)));
    chk("async_reset_tries", 32'(dut.r_tries), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1,0,0,0, 2'd0,2'd0);
    chk("reentry_tries", 32'(dut.r_tries), 32'd0);
    step(0,0,0,0, 2'd0,2'd0);
    chk("first_edge_wait", 32'(obs), 32'(o(0,1,SE,SN,2'd0,0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
